// File: rtl/ram_arbiter.sv
// Two-master (fetch/data) arbiter onto a single-port RAM backend, data has priority.
// Latency: 2 cycles minimum (IDLE issue cycle, then BUSY cycle with ram_ready=1).
// Backpressure: core masters stall on iwait/dwait; the backend stalls via ram_ready; err is sticky on timeout.
module ram_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        iren,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dren,
    input  logic [3:0]  dwen,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ram_req,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready,
    output logic        err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_addr;
    logic [3:0]      r_wen;
    logic [31:0]     r_wdata;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    logic            w_dreq;
    logic            w_busy;
    logic            w_load_d;
    logic            w_load_i;
    logic            w_icomp;
    logic            w_dcomp;

    // A data request is either a read or any byte-enabled write.
    assign w_dreq = dren | (|dwen);
    assign w_busy = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and latch-enable decode; data wins over fetch in IDLE, BUSY always returns to IDLE on ram_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_load_d    = 1'b0;
        w_load_i    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dreq) begin
                    w_load_d    = 1'b1;
                    w_state_nxt = BUSY_D;
                end else if (iren) begin
                    w_load_i    = 1'b1;
                    w_state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (ram_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture the winning request so the backend sees stable address/enables/data for the whole access.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_addr  <= 32'd0;
            r_wen   <= 4'd0;
            r_wdata <= 32'd0;
        end else if (w_load_d) begin
            r_addr  <= daddr;
            r_wen   <= dwen;
            r_wdata <= dstore;
        end else if (w_load_i) begin
            r_addr  <= iaddr;
            r_wen   <= 4'd0;
            r_wdata <= 32'd0;
        end
    end

    // Wait counter: held at zero in IDLE so every access starts counting from zero; saturates at TIMEOUT.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (!w_busy) begin
            r_cnt <= '0;
        end else if (!ram_ready && (r_cnt != CW'(TIMEOUT))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Sticky timeout flag, raised on the BUSY cycle that brings the counter to TIMEOUT; the access keeps waiting.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_err <= 1'b0;
        end else if (w_busy && !ram_ready && (r_cnt == CW'(TIMEOUT - 1))) begin
            r_err <= 1'b1;
        end
    end

    // Completion is reported only if the master still asks for exactly what was latched; otherwise the result is dropped.
    always_comb begin
        w_icomp = (r_state == BUSY_I) && ram_ready && iren && (iaddr == r_addr);
        w_dcomp = (r_state == BUSY_D) && ram_ready && w_dreq &&
                  (daddr == r_addr) && (dwen == r_wen);
    end

    // Core-side and backend-side outputs.
    always_comb begin
        iwait     = iren & ~w_icomp;
        iload     = w_icomp ? ram_rdata : 32'd0;
        dwait     = w_dreq & ~w_dcomp;
        dload     = w_dcomp ? ram_rdata : 32'd0;
        ram_req   = w_busy;
        ram_addr  = {r_addr[31:2], 2'b00};
        ram_wen   = w_busy ? r_wen : 4'd0;
        ram_wdata = r_wdata;
        err       = r_err;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic        clk;
    logic        nrst;
    logic        iren;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dren;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ram_req;
    logic [31:0] ram_addr;
    logic [3:0]  ram_wen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        err;

    int n_tests;
    int n_fail;

    ram_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .iren      (iren),
        .iaddr     (iaddr),
        .iload     (iload),
        .iwait     (iwait),
        .dren      (dren),
        .dwen      (dwen),
        .daddr     (daddr),
        .dstore    (dstore),
        .dload     (dload),
        .dwait     (dwait),
        .ram_req   (ram_req),
        .ram_addr  (ram_addr),
        .ram_wen   (ram_wen),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are then changed and outputs checked at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; iren = 1'b0; iaddr = '0; dren = 1'b0; dwen = '0;
        daddr = '0; dstore = '0; ram_rdata = '0; ram_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL reset_ram_req got=%b exp=0", ram_req); end
        n_tests++; if (ram_wen !== 4'h0) begin n_fail++; $display("FAIL reset_ram_wen got=%h exp=0", ram_wen); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        n_tests++; if (iwait !== 1'b0 || dwait !== 1'b0) begin n_fail++; $display("FAIL reset_wait got=%b%b exp=00", iwait, dwait); end
        n_tests++; if (iload !== 32'h0 || dload !== 32'h0) begin n_fail++; $display("FAIL reset_load got=%h/%h exp=0", iload, dload); end
        tick();
        nrst = 1'b1;
    endtask

    task automatic test_fetch();
        // IDLE issue cycle
        iren = 1'b1; iaddr = 32'h100;
        @(negedge clk);
        n_tests++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_req got=%b exp=0", ram_req); end
        n_tests++; if (iwait !== 1'b1 || iload !== 32'h0) begin n_fail++; $display("FAIL fetch_idle_wait got=%b/%h exp=1/0", iwait, iload); end
        tick();
        // BUSY_I with ram_ready
        ram_ready = 1'b1; ram_rdata = 32'h0000_0013;
        @(negedge clk);
        n_tests++; if (ram_req !== 1'b1 || ram_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_busy_addr got=%b/%h exp=1/100", ram_req, ram_addr); end
        n_tests++; if (ram_wen !== 4'h0) begin n_fail++; $display("FAIL fetch_busy_wen got=%h exp=0", ram_wen); end
        n_tests++; if (iwait !== 1'b0 || iload !== 32'h13) begin n_fail++; $display("FAIL fetch_complete got=%b/%h exp=0/13", iwait, iload); end
        tick();
        iren = 1'b0; ram_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (ram_req !== 1'b0 || iload !== 32'h0) begin n_fail++; $display("FAIL fetch_after got=%b/%h exp=0/0", ram_req, iload); end
        tick();
    endtask

    task automatic test_priority();
        dren = 1'b1; daddr = 32'h203; iren = 1'b1; iaddr = 32'h40;
        @(negedge clk);
        n_tests++; if (dwait !== 1'b1 || iwait !== 1'b1) begin n_fail++; $display("FAIL prio_idle_wait got=%b%b exp=11", dwait, iwait); end
        tick();
        ram_ready = 1'b1; ram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++; if (ram_addr !== 32'h200 || ram_wen !== 4'h0) begin n_fail++; $display("FAIL prio_data_addr got=%h/%h exp=200/0", ram_addr, ram_wen); end
        n_tests++; if (dwait !== 1'b0 || dload !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL prio_data_done got=%b/%h exp=0/deadbeef", dwait, dload); end
        n_tests++; if (iwait !== 1'b1 || iload !== 32'h0) begin n_fail++; $display("FAIL prio_fetch_held got=%b/%h exp=1/0", iwait, iload); end
        tick();
        // back in IDLE: no back-to-back issue, the fetch is arbitrated here
        dren = 1'b0; ram_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (ram_req !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b0) begin n_fail++; $display("FAIL prio_gap got=%b%b%b exp=010", ram_req, iwait, dwait); end
        tick();
        ram_ready = 1'b1; ram_rdata = 32'h1111_1111;
        @(negedge clk);
        n_tests++; if (ram_addr !== 32'h40 || iwait !== 1'b0 || iload !== 32'h1111_1111) begin n_fail++; $display("FAIL prio_fetch_done got=%h/%b/%h exp=40/0/11111111", ram_addr, iwait, iload); end
        tick();
        iren = 1'b0; ram_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL prio_end_req got=%b exp=0", ram_req); end
        tick();
    endtask

    task automatic test_write();
        dwen = 4'b0100; daddr = 32'h22; dstore = 32'h00AB_0000;
        @(negedge clk);
        n_tests++; if (dwait !== 1'b1 || ram_req !== 1'b0) begin n_fail++; $display("FAIL wr_idle got=%b/%b exp=1/0", dwait, ram_req); end
        tick();
        // store data changes after issue; the backend must keep the latched word
        dstore = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++; if (ram_req !== 1'b1 || ram_wen !== 4'b0100 || ram_addr !== 32'h20 || ram_wdata !== 32'h00AB_0000) begin
                n_fail++; $display("FAIL wr_busy%0d got=%b/%h/%h/%h exp=1/4/20/00ab0000", k, ram_req, ram_wen, ram_addr, ram_wdata); end
            n_tests++; if (dwait !== 1'b1 || dload !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL wr_wait%0d got=%b/%h/%b exp=1/0/0", k, dwait, dload, err); end
            tick();
        end
        ram_ready = 1'b1; ram_rdata = 32'h1234_5678;
        @(negedge clk);
        n_tests++; if (dwait !== 1'b0 || dload !== 32'h1234_5678 || ram_wen !== 4'b0100) begin n_fail++; $display("FAIL wr_done got=%b/%h/%h exp=0/12345678/4", dwait, dload, ram_wen); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err got=%b exp=0", err); end
        tick();
        dwen = 4'b0000; ram_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (ram_req !== 1'b0 || ram_wen !== 4'h0 || dwait !== 1'b0 || dload !== 32'h0) begin n_fail++; $display("FAIL wr_end got=%b/%h/%b/%h exp=0/0/0/0", ram_req, ram_wen, dwait, dload); end
        tick();
    endtask

    task automatic test_redirect();
        iren = 1'b1; iaddr = 32'h10;
        @(negedge clk);
        tick();
        iaddr = 32'h80;
        @(negedge clk);
        n_tests++; if (ram_addr !== 32'h10 || iwait !== 1'b1) begin n_fail++; $display("FAIL redir_busy got=%h/%b exp=10/1", ram_addr, iwait); end
        tick();
        ram_ready = 1'b1; ram_rdata = 32'h0000_AAAA;
        @(negedge clk);
        n_tests++; if (ram_addr !== 32'h10 || iwait !== 1'b1 || iload !== 32'h0) begin n_fail++; $display("FAIL redir_discard got=%h/%b/%h exp=10/1/0", ram_addr, iwait, iload); end
        tick();
        ram_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (ram_req !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL redir_idle got=%b/%b exp=0/1", ram_req, iwait); end
        tick();
        ram_ready = 1'b1; ram_rdata = 32'h0000_BBBB;
        @(negedge clk);
        n_tests++; if (ram_addr !== 32'h80 || iwait !== 1'b0 || iload !== 32'h0000_BBBB) begin n_fail++; $display("FAIL redir_done got=%h/%b/%h exp=80/0/bbbb", ram_addr, iwait, iload); end
        tick();
        iren = 1'b0; ram_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (iwait !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL redir_end got=%b/%b exp=0/0", iwait, err); end
        tick();
    endtask

    task automatic test_timeout();
        dren = 1'b1; daddr = 32'h300;
        @(negedge clk);
        tick();
        // four BUSY cycles without ram_ready; err rises only after the fourth
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++; if (err !== 1'b0 || ram_req !== 1'b1) begin n_fail++; $display("FAIL to_wait%0d got=%b/%b exp=0/1", k, err, ram_req); end
            tick();
        end
        @(negedge clk);
        n_tests++; if (err !== 1'b1 || ram_req !== 1'b1 || dwait !== 1'b1) begin n_fail++; $display("FAIL to_err got=%b/%b/%b exp=1/1/1", err, ram_req, dwait); end
        tick();
        @(negedge clk);
        n_tests++; if (err !== 1'b1 || ram_addr !== 32'h300) begin n_fail++; $display("FAIL to_sticky got=%b/%h exp=1/300", err, ram_addr); end
        tick();
        // asynchronous reset mid-access
        nrst = 1'b0; dren = 1'b0;
        #1;
        n_tests++; if (err !== 1'b0 || ram_req !== 1'b0 || ram_wen !== 4'h0) begin n_fail++; $display("FAIL to_async_rst got=%b/%b/%h exp=0/0/0", err, ram_req, ram_wen); end
        ram_ready = 1'b1; ram_rdata = 32'h5555_5555;
        @(negedge clk);
        n_tests++; if (dload !== 32'h0 || ram_addr !== 32'h0) begin n_fail++; $display("FAIL to_rst_nodone got=%h/%h exp=0/0", dload, ram_addr); end
        tick();
        nrst = 1'b1; ram_ready = 1'b0; iren = 1'b1; iaddr = 32'h4;
        @(negedge clk);
        n_tests++; if (ram_req !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL to_post_idle got=%b/%b exp=0/1", ram_req, iwait); end
        tick();
        ram_ready = 1'b1; ram_rdata = 32'h0000_0005;
        @(negedge clk);
        n_tests++; if (ram_addr !== 32'h4 || iload !== 32'h5 || iwait !== 1'b0) begin n_fail++; $display("FAIL to_post_fetch got=%h/%h/%b exp=4/5/0", ram_addr, iload, iwait); end
        tick();
        iren = 1'b0; ram_ready = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_redirect();
        test_timeout();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles a backend access may wait for ram_ready before err is raised.
REQ-002 SHALL have port clk  in  1  system clock, rising-edge.
REQ-003 SHALL have port nrst  in  1  reset, asynchronous, active-low; one clock and this reset only.
REQ-004 SHALL have port iren  in  1  instruction read request from core fetch.
REQ-005 SHALL have port iaddr  in  32  instruction byte address.
REQ-006 SHALL have port iload  out  32  instruction word returned.
REQ-007 SHALL have port iwait  out  1  instruction access not complete this cycle.
REQ-008 SHALL have port dren  in  1  data read request.
REQ-009 SHALL have port dwen  in  4  byte write enables; any bit set means data write request.
REQ-010 SHALL have port daddr  in  32  data byte address.
REQ-011 SHALL have port dstore  in  32  write data, already lane-aligned.
REQ-012 SHALL have port dload  out  32  data word returned.
REQ-013 SHALL have port dwait  out  1  data access not complete this cycle.
REQ-014 SHALL have port ram_req  out  1  backend access valid.
REQ-015 SHALL have port ram_addr  out  32  backend word address, bits [1:0] forced to 0.
REQ-016 SHALL have port ram_wen  out  4  backend byte enables; 0 means read.
REQ-017 SHALL have port ram_wdata  out  32  backend write data.
REQ-018 SHALL have port ram_rdata  in  32  backend read data, valid when ram_ready=1.
REQ-019 SHALL have port ram_ready  in  1  backend completes the access this cycle.
REQ-020 SHALL have port err  out  1  sticky backend timeout flag.

Function
REQ-021 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-022 In IDLE, dren or |dwen SHALL latch {daddr, dwen, dstore} and move to BUSY_D; otherwise iren SHALL latch iaddr and move to BUSY_I; data has priority.
REQ-023 In BUSY_x, ram_req SHALL be 1 and ram_addr/ram_wen/ram_wdata SHALL come only from latched registers, stable until ram_ready.
REQ-024 In IDLE, ram_req SHALL be 0; minimum request-to-completion latency is 2 cycles (IDLE issue, BUSY with ram_ready=1).
REQ-025 On ram_ready in BUSY_I, with iren=1 and iaddr equal to the latched address: iwait=0 and iload=ram_rdata combinationally for exactly that cycle; then IDLE.
REQ-026 On ram_ready in BUSY_D, with the data request still asserted and daddr/dwen equal to the latched values: dwait=0 and dload=ram_rdata for that cycle (dload=ram_rdata also for writes); then IDLE.
REQ-027 If the request is withdrawn or changed before ram_ready (e.g. fetch redirect), the backend access SHALL still complete (a write still commits); the result SHALL be discarded, wait kept high, the FSM SHALL return to IDLE and then re-arbitrate.
REQ-028 iwait SHALL be 1 whenever iren=1 and no matching completion occurs this cycle; iwait SHALL be 0 when iren=0.
REQ-029 dwait SHALL be 1 whenever a data request is asserted without matching completion this cycle; dwait SHALL be 0 with no data request.
REQ-030 iload/dload SHALL be 0 in any cycle without their respective completion.
REQ-031 A wait counter SHALL clear on entering BUSY_x and increment each BUSY cycle without ram_ready; reaching TIMEOUT SHALL set err=1, held until reset; the access keeps waiting.
REQ-032 Simultaneous ram_ready and new core requests SHALL be arbitrated only from IDLE on the following cycle; there is no back-to-back issue.

Reset
REQ-033 On nrst=0, asynchronously: state=IDLE, latched registers=0, wait counter=0, err=0, ram_req=0, ram_wen=0.
REQ-034 Reset asserted mid-access SHALL abandon the access with no completion reported; after release the FSM SHALL arbitrate from IDLE.

Verification
REQ-035 Fetch with iren=1, iaddr=0x100, ram_ready 1 cycle after ram_req, ram_rdata=0x00000013 -> ram_addr=0x100; iwait=0 and iload=0x13 in the completion cycle only; total 2 cycles.
REQ-036 dren=1 (daddr=0x203) and iren=1 (iaddr=0x40) in the same IDLE cycle -> data served first with ram_addr=0x200; the fetch issues in the cycle after data completion.
REQ-037 dwen=4'b0100, daddr=0x22, dstore=0x00AB0000 -> ram_wen=4'b0100, ram_wdata=0x00AB0000, ram_addr=0x20; dwait=0 for one cycle on ram_ready.
REQ-038 iaddr changes 0x10 -> 0x80 while BUSY_I -> access to 0x10 completes with iwait still 1; a new access to 0x80 follows; iwait=0 only on that access's completion.
REQ-039 TIMEOUT=4, ram_ready held 0 -> err=1 after 4 BUSY cycles, ram_req stays 1; nrst pulse -> err=0, ram_req=0, state IDLE.
